// File: rtl/sw_switcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_switcher_pkg
//  Description : Shared constants, state encoding and event-framing helpers
//                for the software switcher stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_switcher_pkg;

    // Default word width; the top bit marks metadata words.
    localparam int unsigned c_DATA_WIDTH = 65;
    localparam int unsigned c_META_BIT   = c_DATA_WIDTH - 1;

    // Tag byte (just below the metadata flag) identifying an event footer.
    localparam logic [7:0] c_EVT_FOOTER_BYTE = 8'hCD;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // A footer is a flagged word carrying the footer tag; flagged headers
    // and unflagged words with the same byte are ordinary payload.
    function automatic logic is_footer(input logic [c_DATA_WIDTH-1:0] word);
        return word[c_META_BIT] && (word[c_META_BIT-1 -: 8] == c_EVT_FOOTER_BYTE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first active
//                request searching upward from i_ptr+1, wrapping to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_gnt_valid
);

    // Two descending passes: the lowest index at or below the pointer is the
    // fallback, then the lowest index above the pointer overrides it.
    always_comb begin
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (i_req[i] && (IDX_W'(i) <= i_ptr)) begin
                o_gnt_idx   = IDX_W'(i);
                o_gnt_valid = 1'b1;
            end
        end
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (i_req[i] && (IDX_W'(i) > i_ptr)) begin
                o_gnt_idx   = IDX_W'(i);
                o_gnt_valid = 1'b1;
            end
        end
        o_gnt = o_gnt_valid ? (NUM_REQ'(1) << o_gnt_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/sw_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sw_event_arbiter
//  Description : Event-granular N:1 round-robin arbiter. Owns one input
//                buffer from grant until its footer is popped and forwards
//                every popped word one cycle later to the output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_event_arbiter
    import sw_switcher_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = c_DATA_WIDTH,
    parameter int unsigned TOTAL_INPUTS    = 2,
    parameter int unsigned MAX_EVENT_WORDS = 4096,
    parameter int unsigned CNT_WIDTH       = 32,
    localparam int unsigned c_IDX_W        = (TOTAL_INPUTS > 1) ? $clog2(TOTAL_INPUTS) : 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [TOTAL_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [TOTAL_INPUTS-1:0]            in_empty,
    output logic [TOTAL_INPUTS-1:0]            in_ren,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_we,
    input  logic                               out_almost_full,
    output logic                               grant_valid,
    output logic [c_IDX_W-1:0]                 grant_idx,
    output logic [CNT_WIDTH-1:0]               evt_count,
    output logic                               err_watchdog
);

    localparam int unsigned       c_WCNT_W   = $clog2(MAX_EVENT_WORDS + 1);
    localparam logic [c_WCNT_W-1:0] c_WD_LIMIT = c_WCNT_W'(MAX_EVENT_WORDS);
    localparam logic [c_WCNT_W-1:0] c_WD_LAST  = c_WCNT_W'(MAX_EVENT_WORDS - 1);

    arb_state_t               r_state;
    logic [c_IDX_W-1:0]       r_ptr;
    logic [c_IDX_W-1:0]       r_grant_idx;
    logic [TOTAL_INPUTS-1:0]  r_grant_oh;
    logic                     r_grant_valid;
    logic [c_WCNT_W-1:0]      r_word_cnt;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_out_we;
    logic [CNT_WIDTH-1:0]     r_evt_count;
    logic                     r_err_watchdog;

    logic [DATA_WIDTH-1:0]    w_in_word [TOTAL_INPUTS];
    logic [DATA_WIDTH-1:0]    w_head;
    logic                     w_head_empty;
    logic                     w_footer;
    logic                     w_pop;
    logic [TOTAL_INPUTS-1:0]  w_arb_gnt;
    logic [c_IDX_W-1:0]       w_arb_idx;
    logic                     w_arb_valid;

    // Unpack the flat head-of-buffer bus into one word per input.
    for (genvar gi = 0; gi < TOTAL_INPUTS; gi++) begin : g_in_word
        assign w_in_word[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_head       = w_in_word[r_grant_idx];
    assign w_head_empty = |(in_empty & r_grant_oh);

    // Footer decode: reuse the package helper at the native width, otherwise
    // decode the same fields at the configured width.
    if (DATA_WIDTH == c_DATA_WIDTH) begin : g_footer_pkg
        assign w_footer = is_footer(w_head);
    end else begin : g_footer_generic
        assign w_footer = w_head[DATA_WIDTH-1] &&
                          (w_head[DATA_WIDTH-2 -: 8] == c_EVT_FOOTER_BYTE);
    end

    // Pops only happen for the owning input, only while it has data and the
    // output buffer still has room beyond the word already in flight.
    assign w_pop  = (r_state == XFER) && !w_head_empty && !out_almost_full;
    assign in_ren = w_pop ? r_grant_oh : '0;

    rr_arbiter #(
        .NUM_REQ (TOTAL_INPUTS),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req       (~in_empty),
        .i_ptr       (r_ptr),
        .o_gnt       (w_arb_gnt),
        .o_gnt_idx   (w_arb_idx),
        .o_gnt_valid (w_arb_valid)
    );

    // Grant FSM, output register, event counter and watchdog.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_ptr          <= c_IDX_W'(TOTAL_INPUTS - 1);
            r_grant_idx    <= '0;
            r_grant_oh     <= '0;
            r_grant_valid  <= 1'b0;
            r_word_cnt     <= '0;
            r_out_data     <= '0;
            r_out_we       <= 1'b0;
            r_evt_count    <= '0;
            r_err_watchdog <= 1'b0;
        end else begin
            r_out_we <= w_pop;
            if (w_pop) begin
                r_out_data <= w_head;
            end
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant_idx   <= w_arb_idx;
                        r_grant_oh    <= w_arb_gnt;
                        r_grant_valid <= 1'b1;
                        r_ptr         <= w_arb_idx;
                        r_word_cnt    <= '0;
                        r_state       <= XFER;
                    end
                end
                XFER: begin
                    if (w_pop) begin
                        if (r_word_cnt != c_WD_LIMIT) begin
                            r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
                        end
                        if (!w_footer && (r_word_cnt >= c_WD_LAST)) begin
                            r_err_watchdog <= 1'b1;
                        end
                        if (w_footer) begin
                            r_state       <= IDLE;
                            r_grant_valid <= 1'b0;
                            r_evt_count   <= r_evt_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data     = r_out_data;
    assign out_we       = r_out_we;
    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_grant_idx;
    assign evt_count    = r_evt_count;
    assign err_watchdog = r_err_watchdog;

endmodule
`default_nettype wire

// File: tb/tb_sw_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_event_arbiter
//  Description : Directed self-checking bench for sw_event_arbiter with FWFT
//                input buffer models and an in-order output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_event_arbiter;

    localparam int DW   = 65;
    localparam int NI   = 2;
    localparam int MAXW = 8;
    localparam int CW   = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [NI*DW-1:0] in_data = '0;
    logic [NI-1:0]    in_empty = '1;
    logic [NI-1:0]    in_ren;
    logic [DW-1:0]    out_data;
    logic             out_we;
    logic             out_almost_full = 1'b0;
    logic             grant_valid;
    logic [0:0]       grant_idx;
    logic [CW-1:0]    evt_count;
    logic             err_watchdog;

    always #5 clock = ~clock;

    sw_event_arbiter #(
        .DATA_WIDTH      (DW),
        .TOTAL_INPUTS    (NI),
        .MAX_EVENT_WORDS (MAXW),
        .CNT_WIDTH       (CW)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .in_ren          (in_ren),
        .out_data        (out_data),
        .out_we          (out_we),
        .out_almost_full (out_almost_full),
        .grant_valid     (grant_valid),
        .grant_idx       (grant_idx),
        .evt_count       (evt_count),
        .err_watchdog    (err_watchdog)
    );

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] m_exp;
    logic [DW-1:0] m_drop;
    logic [NI-1:0] pend = '0;
    bit            prev_ren = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            n_we = 0;

    // Word layout: flag | tag byte | 24'h0 | src | evt | idx
    function automatic logic [DW-1:0] mk(bit flag, logic [7:0] tag, int src, int evt, int idx);
        return {flag, tag, 24'h0, 8'(src), 8'(evt), 16'(idx)};
    endfunction

    // Header flagged with A5, footer flagged with CD, payload unflagged; word 2
    // deliberately carries CD without the flag and must stay payload.
    function automatic logic [DW-1:0] evw(int src, int evt, int idx, int n);
        if (idx == 0)     return mk(1'b1, 8'hA5, src, evt, idx);
        if (idx == n - 1) return mk(1'b1, 8'hCD, src, evt, idx);
        if (idx == 2)     return mk(1'b0, 8'hCD, src, evt, idx);
        return mk(1'b0, 8'h11, src, evt, idx);
    endfunction

    task automatic push_q(int src, logic [DW-1:0] w);
        if (src == 0) q0.push_back(w);
        else          q1.push_back(w);
    endtask

    task automatic event_push(int src, int evt, int n, bit to_q, bit to_sb);
        for (int i = 0; i < n; i++) begin
            if (to_q)  push_q(src, evw(src, evt, i, n));
            if (to_sb) sb.push_back(evw(src, evt, i, n));
        end
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input buffer models: pop what the DUT strobed at the last edge, then
    // present the new FWFT heads.
    always @(posedge clock) begin
        #1;
        if (pend[0] && q0.size() > 0) m_drop = q0.pop_front();
        if (pend[1] && q1.size() > 0) m_drop = q1.pop_front();
        #1;
        in_empty[0]       = (q0.size() == 0);
        in_empty[1]       = (q1.size() == 0);
        in_data[DW-1:0]   = (q0.size() > 0) ? q0[0] : '0;
        in_data[2*DW-1:DW] = (q1.size() > 0) ? q1[0] : '0;
    end

    // Output monitor: order via scoreboard, 1-cycle pop-to-write latency and
    // pop-strobe legality.
    always @(negedge clock) begin
        if (!reset_n) begin
            pend     = '0;
            prev_ren = 1'b0;
        end else begin
            if (out_we) begin
                n_we++;
                n_tests++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_extra: observed write %0h expected no write", out_data);
                end
                if (sb.size() != 0) begin
                    m_exp = sb.pop_front();
                    n_tests++;
                    assert (out_data === m_exp) else begin
                        n_fail++;
                        $error("FAIL out_data: observed %0h expected %0h", out_data, m_exp);
                    end
                end
            end
            if (out_we || prev_ren) begin
                n_tests++;
                assert (out_we === prev_ren) else begin
                    n_fail++;
                    $error("FAIL latency: observed out_we %0b expected %0b", out_we, prev_ren);
                end
            end
            if (in_ren != '0) begin
                n_tests++;
                assert ($onehot(in_ren) && ((in_ren & in_empty) == '0) && grant_valid &&
                        (in_ren == (NI'(1) << grant_idx))) else begin
                    n_fail++;
                    $error("FAIL ren_legal: observed ren %b empty %b gidx %0d gv %0b expected one-hot granted non-empty",
                           in_ren, in_empty, grant_idx, grant_valid);
                end
            end
            prev_ren = |in_ren;
            pend     = in_ren;
        end
    end

    task automatic reset_dut();
        @(posedge clock); #1;
        reset_n         = 1'b0;
        out_almost_full = 1'b0;
        q0.delete(); q1.delete(); sb.delete();
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int k = 0;
        while (!(evt_count == CW'(target) && !grant_valid && sb.size() == 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        n_tests++;
        assert (evt_count === CW'(target) && grant_valid === 1'b0 && sb.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_done: observed evt_count %0d gv %0b pending %0d expected evt_count %0d gv 0 pending 0",
                   tag, evt_count, grant_valid, sb.size(), target);
        end
    endtask

    task automatic wait_writes(input int target, input int budget);
        int k = 0;
        while (n_we < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("wait_writes", 128'(n_we >= target), 128'(1));
    endtask

    initial begin
        int base, cnt, k, bp_ren, bp_we, viol;

        // Reset state
        #12;
        check("rst_out_we", out_we, 0);
        check("rst_out_data", out_data, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_evt_count", evt_count, 0);
        check("rst_err_wd", err_watchdog, 0);
        check("rst_in_ren", in_ren, 0);
        @(posedge clock); #3;
        reset_n = 1'b1;

        // Single 5-word event from input 0
        @(posedge clock); #1;
        base = n_we;
        event_push(0, 0, 5, 1'b1, 1'b1);
        wait_done("single", 1, 60);
        check("single_writes", n_we - base, 5);
        check("single_gv", grant_valid, 0);
        check("single_evt", evt_count, 1);

        // Fairness: 3 events each side, strict alternation from input 0
        reset_dut();
        @(posedge clock); #1;
        for (int e = 0; e < 3; e++) begin
            event_push(0, e, 4, 1'b1, 1'b0);
            event_push(1, e, 4, 1'b1, 1'b0);
        end
        for (int e = 0; e < 3; e++) begin
            event_push(0, e, 4, 1'b0, 1'b1);
            event_push(1, e, 4, 1'b0, 1'b1);
        end
        wait_done("fair", 6, 200);
        check("fair_evt", evt_count, 6);

        // Backpressure for 10 cycles in the middle of a 7-word event
        reset_dut();
        @(posedge clock); #1;
        base = n_we;
        event_push(0, 0, 7, 1'b1, 1'b1);
        wait_writes(base + 3, 100);
        @(posedge clock); #1;
        out_almost_full = 1'b1;
        bp_ren = 0;
        bp_we  = 0;
        repeat (10) begin
            @(negedge clock);
            if (in_ren != '0) bp_ren++;
            if (out_we) bp_we++;
        end
        check("bp_no_pop", bp_ren, 0);
        check("bp_we_max1", 128'(bp_we <= 1), 128'(1));
        @(posedge clock); #1;
        out_almost_full = 1'b0;
        wait_done("bp", 1, 100);
        check("bp_total", n_we - base, 7);

        // Starved owner: input 1 stalls after 2 words while input 0 waits
        reset_dut();
        @(posedge clock); #1;
        base = n_we;
        push_q(1, evw(1, 0, 0, 5));
        push_q(1, evw(1, 0, 1, 5));
        event_push(1, 0, 5, 1'b0, 1'b1);
        event_push(0, 0, 4, 1'b0, 1'b1);
        wait_writes(base + 2, 50);
        @(posedge clock); #1;
        event_push(0, 0, 4, 1'b1, 1'b0);
        viol = 0;
        repeat (20) begin
            @(negedge clock);
            if (grant_idx !== 1'b1 || grant_valid !== 1'b1 || in_ren[0] !== 1'b0) viol++;
        end
        check("starve_hold", viol, 0);
        @(posedge clock); #1;
        for (int i = 2; i < 5; i++) push_q(1, evw(1, 0, i, 5));
        wait_done("starve", 2, 100);
        check("starve_total", n_we - base, 9);

        // Watchdog: 12 unframed words, then a footer
        reset_dut();
        @(posedge clock); #1;
        for (int i = 0; i < 12; i++) begin
            push_q(0, mk(1'b0, 8'h22, 0, 9, i));
            sb.push_back(mk(1'b0, 8'h22, 0, 9, i));
        end
        cnt = 0;
        k   = 0;
        while (cnt < 12 && k < 200) begin
            @(negedge clock);
            k++;
            if (out_we) begin
                cnt++;
                check($sformatf("wd_flag_w%0d", cnt), err_watchdog, 128'(cnt >= MAXW));
            end
        end
        check("wd_continue", cnt, 12);
        @(posedge clock); #1;
        push_q(0, mk(1'b1, 8'hCD, 0, 9, 12));
        sb.push_back(mk(1'b1, 8'hCD, 0, 9, 12));
        wait_done("wd", 1, 50);
        check("wd_sticky", err_watchdog, 1);

        // Reset during the 3rd word of an event
        reset_dut();
        @(posedge clock); #1;
        base = n_we;
        event_push(0, 0, 5, 1'b1, 1'b1);
        wait_writes(base + 2, 50);
        check("mid_ren_w3", in_ren, 2'b01);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_in_ren", in_ren, 0);
        check("mid_out_we", out_we, 0);
        check("mid_out_data", out_data, 0);
        check("mid_gv", grant_valid, 0);
        check("mid_gidx", grant_idx, 0);
        check("mid_evt", evt_count, 0);
        check("mid_err", err_watchdog, 0);
        @(posedge clock); #1;
        q0.delete(); q1.delete(); sb.delete();
        @(posedge clock); #3;
        reset_n = 1'b1;
        check("mid_evt_after", evt_count, 0);
        @(posedge clock); #1;
        event_push(0, 1, 4, 1'b1, 1'b1);
        event_push(1, 1, 4, 1'b1, 1'b1);
        k = 0;
        while (!grant_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("mid_first_gv", grant_valid, 1);
        check("mid_first_gidx", grant_idx, 0);
        wait_done("mid", 2, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish before 500000");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
